// File: rtl/gb_fb_pkg.sv
// Shared constants and types for the framebuffer write scheduler.
//   FB_WIDTH/FB_HEIGHT : framebuffer geometry (160x144)
//   FB_SIZE            : number of entries; valid addresses are 0..FB_SIZE-1
//   FB_ADDR_W          : framebuffer address width
//   fb_clr_state_t     : clear engine states
package gb_fb_pkg;

  localparam int unsigned FB_WIDTH  = 160;
  localparam int unsigned FB_HEIGHT = 144;
  localparam int unsigned FB_SIZE   = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_W = 15;

  typedef logic [1:0]           fb_color_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CLEAR = 2'd2
  } fb_clr_state_t;

  localparam fb_addr_t FB_LAST = fb_addr_t'(FB_SIZE - 1);

endpackage

// File: rtl/fb_write_sched_if.sv
// Bundle of request/response signals around the framebuffer write scheduler.
//   ppu_*  : PPU pixel stream and vsync
//   clr_*  : clear request (start/sync/color) and status (busy/done)
//   fb_*   : framebuffer RAM write port A
// slave  : view used by the scheduler
// master : view used by whatever drives the requests and watches the RAM port
interface fb_write_sched_if;
  import gb_fb_pkg::*;

  logic      ppu_vs;
  logic      ppu_we;
  fb_addr_t  ppu_addr;
  fb_color_t ppu_color;
  logic      clr_start;
  logic      clr_sync;
  fb_color_t clr_color;
  logic      clr_busy;
  logic      clr_done;
  logic      fb_we;
  fb_addr_t  fb_addr;
  fb_color_t fb_din;

  modport slave (
    input  ppu_vs, ppu_we, ppu_addr, ppu_color, clr_start, clr_sync, clr_color,
    output clr_busy, clr_done, fb_we, fb_addr, fb_din
  );

  modport master (
    output ppu_vs, ppu_we, ppu_addr, ppu_color, clr_start, clr_sync, clr_color,
    input  clr_busy, clr_done, fb_we, fb_addr, fb_din
  );

endinterface

// File: rtl/fb_clear_engine.sv
// Clear engine: walks a pointer over the whole framebuffer writing one colour.
//   clk, rst  : clock, asynchronous active-low reset
//   start_i   : clear request pulse (ignored while busy)
//   sync_i    : with start_i, 1 = wait for vs_i before filling
//   color_i   : fill colour, latched on an accepted start
//   vs_i      : PPU vsync level
//   stall_i   : PPU owns the port this cycle; no clear write is issued
//   req_o     : engine wants the port this cycle
//   addr_o    : address of the pending clear write
//   color_o   : latched fill colour
//   busy_o    : accepted start until the final write is issued
//   done_o    : one-cycle pulse coincident with the final write on the RAM port
module fb_clear_engine
  import gb_fb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start_i,
  input  logic      sync_i,
  input  fb_color_t color_i,
  input  logic      vs_i,
  input  logic      stall_i,
  output logic      req_o,
  output fb_addr_t  addr_o,
  output fb_color_t color_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam logic [1:0] StIdle  = IDLE;
  localparam logic [1:0] StArmed = ARMED;
  localparam logic [1:0] StClear = CLEAR;

  logic [1:0] state_q, state_d;
  fb_addr_t   ptr_q, ptr_d;
  fb_color_t  col_q, col_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // busy_q is always low here, so any start is accepted.
        if (start_i) begin
          col_d   = color_i;
          busy_d  = 1'b1;
          ptr_d   = '0;
          state_d = sync_i ? StArmed : StClear;
        end
      end
      StArmed: begin
        if (vs_i) begin
          ptr_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (!stall_i) begin
          if (ptr_q == FB_LAST) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_o   = (state_q == StClear);
  assign addr_o  = ptr_q;
  assign color_o = col_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler (port A, tclk domain).
// The PPU pixel stream always wins the port; the clear engine fills the
// remaining cycles. All RAM-side outputs are registered (latency 1).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave view of fb_write_sched_if (PPU in, clear ctl/status, RAM port out)
module fb_write_sched
  import gb_fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fb_write_sched_if.slave  bus
);

  logic      clr_req;
  fb_addr_t  clr_addr;
  fb_color_t clr_col;

  logic      we_q, we_d;
  fb_addr_t  addr_q, addr_d;
  fb_color_t din_q, din_d;

  // Any PPU strobe stalls the clear, even one that is dropped for being out of range.
  fb_clear_engine u_clear (
    .clk     (clk),
    .rst     (rst),
    .start_i (bus.clr_start),
    .sync_i  (bus.clr_sync),
    .color_i (bus.clr_color),
    .vs_i    (bus.ppu_vs),
    .stall_i (bus.ppu_we),
    .req_o   (clr_req),
    .addr_o  (clr_addr),
    .color_o (clr_col),
    .busy_o  (bus.clr_busy),
    .done_o  (bus.clr_done)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    if (bus.ppu_we) begin
      if (bus.ppu_addr <= FB_LAST) begin
        we_d   = 1'b1;
        addr_d = bus.ppu_addr;
        din_d  = bus.ppu_color;
      end
    end else if (clr_req) begin
      we_d   = 1'b1;
      addr_d = clr_addr;
      din_d  = clr_col;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign bus.fb_we   = we_q;
  assign bus.fb_addr = addr_q;
  assign bus.fb_din  = din_q;

endmodule

// File: tb/tb_fb_write_sched.sv
module tb_fb_write_sched;
  import gb_fb_pkg::*;

  logic clk;
  logic rst;

  fb_write_sched_if bus ();

  fb_write_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests;
  int n_fail;

  // Reference model: a clear job is "waiting for vsync" or "filling from next_addr".
  int          m_mode;   // 0 none, 1 waiting for vsync, 2 filling
  int          m_next;
  logic [1:0]  m_col;
  logic        e_we;
  logic [14:0] e_addr;
  logic [1:0]  e_din;
  logic        e_busy;
  logic        e_done;

  typedef struct {
    logic        we;
    logic        vs;
    logic [14:0] addr;
    logic [1:0]  col;
    logic        xwe;
    logic [14:0] xaddr;
    logic [1:0]  xdin;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predict the RAM port and status after the coming edge from the current inputs.
  task automatic model_step();
    bit slot;
    int a;
    if (!rst) begin
      m_mode = 0; m_next = 0; m_col = 2'd0;
      e_we = 1'b0; e_addr = 15'd0; e_din = 2'd0; e_busy = 1'b0; e_done = 1'b0;
      return;
    end
    e_done = 1'b0;
    a = int'(bus.ppu_addr);
    slot = (m_mode == 2) && !bus.ppu_we;
    if (bus.ppu_we && a < int'(FB_SIZE)) begin
      e_we = 1'b1; e_addr = bus.ppu_addr; e_din = bus.ppu_color;
    end else if (slot) begin
      e_we = 1'b1; e_addr = 15'(m_next); e_din = m_col;
    end else begin
      e_we = 1'b0;
    end
    if (m_mode == 2) begin
      if (slot) begin
        if (m_next == int'(FB_SIZE) - 1) begin
          m_mode = 0; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          m_next = m_next + 1;
        end
      end
    end else if (m_mode == 1) begin
      if (bus.ppu_vs) begin
        m_mode = 2; m_next = 0;
      end
    end else if (bus.clr_start) begin
      m_col  = bus.clr_color;
      e_busy = 1'b1;
      m_next = 0;
      m_mode = bus.clr_sync ? 1 : 2;
    end
  endtask

  // One clock: advance the model, let the edge happen, compare every output.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("model", 32'({bus.fb_we, bus.fb_addr, bus.fb_din, bus.clr_busy, bus.clr_done}),
        32'({e_we, e_addr, e_din, e_busy, e_done}));
  endtask

  task automatic idle_inputs();
    bus.ppu_vs = 1'b0; bus.ppu_we = 1'b0; bus.ppu_addr = 15'd0; bus.ppu_color = 2'd0;
    bus.clr_start = 1'b0; bus.clr_sync = 1'b0; bus.clr_color = 2'd0;
  endtask

  initial begin
    int wcnt, seq_err, gaps, dcnt, extra, first, didx, pcnt, inj, bad;
    logic [14:0] daddr;
    logic dbusy;

    n_tests = 0;
    n_fail  = 0;
    vec[0] = '{1'b1, 1'b0, 15'd5,     2'd3, 1'b1, 15'd5,     2'd3};
    vec[1] = '{1'b0, 1'b0, 15'd77,    2'd1, 1'b0, 15'd5,     2'd3};
    vec[2] = '{1'b1, 1'b0, 15'd23039, 2'd2, 1'b1, 15'd23039, 2'd2};
    vec[3] = '{1'b1, 1'b0, 15'd23040, 2'd1, 1'b0, 15'd23039, 2'd2};
    vec[4] = '{1'b1, 1'b0, 15'd32767, 2'd3, 1'b0, 15'd23039, 2'd2};
    vec[5] = '{1'b1, 1'b0, 15'd0,     2'd1, 1'b1, 15'd0,     2'd1};
    vec[6] = '{1'b0, 1'b0, 15'd9,     2'd2, 1'b0, 15'd0,     2'd1};
    vec[7] = '{1'b1, 1'b1, 15'd200,   2'd2, 1'b1, 15'd200,   2'd2};
    vec[8] = '{1'b0, 1'b1, 15'd1,     2'd3, 1'b0, 15'd200,   2'd2};

    // Reset held: a start pulse must not wake anything up.
    rst = 1'b0;
    idle_inputs();
    bus.clr_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_outs", 32'({bus.fb_we, bus.fb_addr, bus.fb_din, bus.clr_busy, bus.clr_done}),
          32'd0);
      bus.clr_start = 1'b0;
    end
    rst = 1'b1;
    cyc();
    chk("post_reset", 32'({bus.fb_we, bus.clr_busy}), 32'd0);

    // Single-cycle PPU priority cases while idle.
    for (int i = 0; i < NV; i++) begin
      bus.ppu_we = vec[i].we; bus.ppu_vs = vec[i].vs;
      bus.ppu_addr = vec[i].addr; bus.ppu_color = vec[i].col;
      cyc();
      chk($sformatf("vec%0d", i), 32'({bus.fb_we, bus.fb_addr, bus.fb_din}),
          32'({vec[i].xwe, vec[i].xaddr, vec[i].xdin}));
    end
    idle_inputs();
    cyc();

    // Immediate clear, with rejected restarts mid-way and on the final-write cycle.
    bus.clr_start = 1'b1; bus.clr_sync = 1'b0; bus.clr_color = 2'd2;
    cyc();
    idle_inputs();
    chk("clr2_busy_rise", 32'(bus.clr_busy), 32'd1);
    wcnt = 0; seq_err = 0; gaps = 0; dcnt = 0; daddr = '0; dbusy = 1'b1;
    for (int i = 0; i < 23100 && dcnt == 0; i++) begin
      cyc();
      idle_inputs();
      if (bus.fb_we) begin
        if (bus.fb_addr != 15'(wcnt) || bus.fb_din != 2'd2) seq_err++;
        wcnt++;
      end else if (wcnt > 0) begin
        gaps++;
      end
      if (bus.clr_done) begin
        dcnt++; daddr = bus.fb_addr; dbusy = bus.clr_busy;
      end
      if (i == 500 || (bus.fb_we && bus.fb_addr == 15'd23038)) begin
        bus.clr_start = 1'b1; bus.clr_color = 2'd1;
      end
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.clr_done) dcnt++;
      if (bus.fb_we) extra++;
    end
    chk("clr2_writes", wcnt, 23040);
    chk("clr2_seq", seq_err, 0);
    chk("clr2_gaps", gaps, 0);
    chk("clr2_done_cnt", dcnt, 1);
    chk("clr2_done_addr", 32'(daddr), 32'd23039);
    chk("clr2_busy_fall", 32'(dbusy), 32'd0);
    chk("clr2_no_restart", extra, 0);

    // Contention: 5 PPU writes in the middle of a clear.
    bus.clr_start = 1'b1; bus.clr_color = 2'd3;
    cyc();
    idle_inputs();
    wcnt = 0; seq_err = 0; pcnt = 0; inj = 0; first = -1; didx = -1; dcnt = 0;
    for (int i = 0; i < 23200 && dcnt == 0; i++) begin
      cyc();
      if (bus.fb_we && bus.fb_din == 2'd3) begin
        if (bus.fb_addr != 15'(wcnt)) seq_err++;
        if (first < 0) first = i;
        wcnt++;
      end
      if (bus.fb_we && bus.fb_din == 2'd1) begin
        if (bus.fb_addr != 15'(100 + pcnt)) seq_err++;
        pcnt++;
      end
      if (bus.clr_done) begin
        dcnt++; didx = i;
      end
      if (wcnt >= 2000 && inj < 5) begin
        bus.ppu_we = 1'b1; bus.ppu_addr = 15'(100 + inj); bus.ppu_color = 2'd1;
        inj++;
      end else begin
        bus.ppu_we = 1'b0;
      end
    end
    idle_inputs();
    chk("clr3_writes", wcnt, 23040);
    chk("clr3_ppu", pcnt, 5);
    chk("clr3_seq", seq_err, 0);
    chk("clr3_span", didx - first + 1, 23045);

    // Deferred clear: parked until vsync, then random traffic until it completes.
    bus.clr_start = 1'b1; bus.clr_sync = 1'b1; bus.clr_color = 2'd2;
    cyc();
    idle_inputs();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (bus.fb_we || !bus.clr_busy) bad++;
    end
    chk("defer_wait", bad, 0);
    bus.ppu_vs = 1'b1;
    cyc();
    bus.ppu_vs = 1'b0;
    chk("defer_lat1", 32'(bus.fb_we), 32'd0);
    cyc();
    chk("defer_first", 32'({bus.fb_we, bus.fb_addr, bus.fb_din}), 32'({1'b1, 15'd0, 2'd2}));
    dcnt = 0;
    for (int i = 0; i < 40000 && dcnt == 0; i++) begin
      bus.ppu_we    = ($urandom_range(0, 15) == 0);
      bus.ppu_addr  = 15'($urandom_range(0, 23100));
      bus.ppu_color = 2'($urandom_range(0, 3));
      bus.ppu_vs    = 1'($urandom_range(0, 1));
      bus.clr_start = ($urandom_range(0, 299) == 0);
      bus.clr_sync  = 1'($urandom_range(0, 1));
      bus.clr_color = 2'($urandom_range(0, 3));
      cyc();
      if (bus.clr_done) dcnt++;
    end
    idle_inputs();
    cyc();
    chk("defer_done", dcnt, 1);
    chk("defer_idle", 32'(bus.clr_busy), 32'd0);

    // Reset in the middle of a clear, then a fresh clear from address 0.
    bus.clr_start = 1'b1; bus.clr_sync = 1'b0; bus.clr_color = 2'd1;
    cyc();
    idle_inputs();
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if (bus.fb_we && bus.fb_addr == 15'd4999) break;
    end
    chk("rst_mid_ptr", 32'(bus.fb_addr), 32'd4999);
    rst = 1'b0;
    #1;
    chk("rst_mid_async", 32'({bus.fb_we, bus.clr_busy, bus.clr_done}), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_after", 32'({bus.fb_we, bus.clr_busy, bus.clr_done}), 32'd0);
    bus.clr_start = 1'b1; bus.clr_color = 2'd3;
    cyc();
    idle_inputs();
    cyc();
    chk("rst_restart", 32'({bus.fb_we, bus.fb_addr, bus.fb_din}), 32'({1'b1, 15'd0, 2'd3}));
    for (int i = 0; i < 50; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
